// File: rtl/logic_4094_pkg.sv
// Shared types and defaults for the CD4094 shift-and-store register emulation.
package logic_4094_pkg;

  localparam int LOGIC_4094_W_DEFAULT = 8;

  // Single-cycle chip-clock edge strobes, mutually exclusive.
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

endpackage

// File: rtl/logic_4094_edge_det.sv
// Chip-clock edge detector with optional input synchronizers for CP, D, STR and OE.
// Macro LOGIC_4094_SYNC_EN inserts a 2-flop synchronizer on every input (2 CLK extra latency).
module logic_edge_det
  import logic_4094_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cp,
  input  logic  d,
  input  logic  str,
  input  logic  oe,
  output edge_t cp_edge,
  output logic  d_s,
  output logic  str_s,
  output logic  oe_s
);

  logic cp_s;
  logic armed;
  logic cp_q;

`ifdef LOGIC_4094_SYNC_EN
  logic [1:0] cp_sync;
  logic [1:0] d_sync;
  logic [1:0] str_sync;
  logic [1:0] oe_sync;
  logic [2:0] arm_sr;

  // Arming waits until the synchronizers carry the real pin level, so a CP
  // already high at reset release still produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp_sync  <= '0;
      d_sync   <= '0;
      str_sync <= '0;
      oe_sync  <= '0;
      arm_sr   <= '0;
    end else begin
      cp_sync  <= {cp_sync[0], cp};
      d_sync   <= {d_sync[0], d};
      str_sync <= {str_sync[0], str};
      oe_sync  <= {oe_sync[0], oe};
      arm_sr   <= {arm_sr[1:0], 1'b1};
    end
  end

  assign cp_s  = cp_sync[1];
  assign d_s   = d_sync[1];
  assign str_s = str_sync[1];
  assign oe_s  = oe_sync[1];
  assign armed = arm_sr[2];
`else
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  assign cp_s  = cp;
  assign d_s   = d;
  assign str_s = str;
  assign oe_s  = oe;
  assign armed = armed_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cp_q <= 1'b0;
    else        cp_q <= cp_s;
  end

  assign cp_edge.rise = armed &  cp_s & ~cp_q;
  assign cp_edge.fall = armed & ~cp_s &  cp_q;

endmodule

// File: rtl/logic_4094.sv
// CD4094 8-stage shift-and-store bus register, clocked from the emulator system clock.
// Optional macro LOGIC_4094_SYNC_EN synchronizes all pin inputs (see logic_edge_det).
module logic_4094
  import logic_4094_pkg::*;
#(
  parameter int WIDTH = LOGIC_4094_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CP,
  input  logic             D,
  input  logic             STR,
  input  logic             OE,
  output logic [WIDTH-1:0] QP,
  output logic             QP_EN,
  output logic             QS1,
  output logic             QS2
);

  edge_t            cp_edge;
  logic             d_s;
  logic             str_s;
  logic             oe_s;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] store;
  logic             qs2_q;
  logic             oe_q;

  logic_edge_det u_edge_det (
    .clk     (CLK),
    .rst_n   (RST_N),
    .cp      (CP),
    .d       (D),
    .str     (STR),
    .oe      (OE),
    .cp_edge (cp_edge),
    .d_s     (d_s),
    .str_s   (str_s),
    .oe_s    (oe_s)
  );

  // A transparent latch in a rise cycle must see the post-shift value.
  always_comb begin
    sr_next = sr;
    if (cp_edge.rise) sr_next = {sr[WIDTH-2:0], d_s};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr    <= '0;
      store <= '0;
      qs2_q <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      sr   <= sr_next;
      oe_q <= oe_s;
      if (str_s)        store <= sr_next;
      if (cp_edge.fall) qs2_q <= sr[WIDTH-1];
    end
  end

  assign QP    = oe_q ? store : '0;
  assign QP_EN = oe_q;
  assign QS1   = sr[WIDTH-1];
  assign QS2   = qs2_q;

endmodule

// File: tb/tb_logic_4094.sv
// Table-driven, scoreboarded bench for logic_4094 (default or LOGIC_4094_SYNC_EN build).
module tb_logic_4094;

`ifdef LOGIC_4094_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2:0] OP_CP   = 3'd1;
  localparam logic [2:0] OP_STRP = 3'd2;
  localparam logic [2:0] OP_STR  = 3'd3;

  typedef struct packed {
    logic [7:0] qp;
    logic       en;
    logic       qs1;
    logic       qs2;
  } out_t;

  typedef struct packed {
    logic [2:0] op;
    logic       d;
    out_t       exp;
  } vec_t;

  logic       CLK;
  logic       RST_N;
  logic       CP;
  logic       D;
  logic       STR;
  logic       OE;
  logic [7:0] QP;
  logic       QP_EN;
  logic       QS1;
  logic       QS2;

  int   n_vec;
  int   n_err;
  out_t sb_q[$];
  vec_t tab_shift[10];
  vec_t tab_walk[8];

  logic_4094 #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CP    (CP),
    .D     (D),
    .STR   (STR),
    .OE    (OE),
    .QP    (QP),
    .QP_EN (QP_EN),
    .QS1   (QS1),
    .QS2   (QS2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(logic [2:0] op, logic d, logic [7:0] qp,
                              logic en, logic qs1, logic qs2);
    vec_t v;
    v.op      = op;
    v.d       = d;
    v.exp.qp  = qp;
    v.exp.en  = en;
    v.exp.qs1 = qs1;
    v.exp.qs2 = qs2;
    return v;
  endfunction

  function automatic out_t mko(logic [7:0] qp, logic en, logic qs1, logic qs2);
    out_t o;
    o.qp  = qp;
    o.en  = en;
    o.qs1 = qs1;
    o.qs2 = qs2;
    return o;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input out_t e);
    sb_q.push_back(e);
  endtask

  task automatic check_front(input string tag);
    out_t e;
    out_t a;
    a = mko(QP, QP_EN, QS1, QS2);
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got qp=%02h en=%0b qs1=%0b qs2=%0b",
               tag, a.qp, a.en, a.qs1, a.qs2);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got qp=%02h en=%0b qs1=%0b qs2=%0b, want qp=%02h en=%0b qs1=%0b qs2=%0b",
                 tag, a.qp, a.en, a.qs1, a.qs2, e.qp, e.en, e.qs1, e.qs2);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    case (v.op)
      OP_CP: begin
        D  = v.d;
        CP = 1'b1;
        repeat (3) tick();
        CP = 1'b0;
        repeat (3) tick();
      end
      OP_STRP: begin
        STR = 1'b1;
        repeat (3) tick();
        STR = 1'b0;
        repeat (3) tick();
      end
      OP_STR: begin
        STR = v.d;
        repeat (3) tick();
      end
      default: tick();
    endcase
  endtask

  task automatic run_table_shift();
    for (int i = 0; i < 10; i++) begin
      push_exp(tab_shift[i].exp);
      apply(tab_shift[i]);
      check_front($sformatf("shift[%0d]", i));
    end
  endtask

  task automatic run_table_walk();
    for (int i = 0; i < 8; i++) begin
      push_exp(tab_walk[i].exp);
      apply(tab_walk[i]);
      check_front($sformatf("walk[%0d]", i));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    tab_shift[0] = mk(OP_STR, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tab_shift[1] = mk(OP_CP,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    tab_shift[2] = mk(OP_CP,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tab_shift[3] = mk(OP_CP,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    tab_shift[4] = mk(OP_CP,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    tab_shift[5] = mk(OP_CP,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tab_shift[6] = mk(OP_CP,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tab_shift[7] = mk(OP_CP,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    tab_shift[8] = mk(OP_CP,  1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    tab_shift[9] = mk(OP_STRP, 1'b0, 8'hB2, 1'b1, 1'b1, 1'b1);

    tab_walk[0] = mk(OP_CP, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    tab_walk[1] = mk(OP_CP, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    tab_walk[2] = mk(OP_CP, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    tab_walk[3] = mk(OP_CP, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
    tab_walk[4] = mk(OP_CP, 1'b1, 8'h1F, 1'b1, 1'b0, 1'b0);
    tab_walk[5] = mk(OP_CP, 1'b1, 8'h3F, 1'b1, 1'b0, 1'b0);
    tab_walk[6] = mk(OP_CP, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
    tab_walk[7] = mk(OP_CP, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);

    RST_N = 1'b1;
    CP    = 1'b1;
    D     = 1'b1;
    STR   = 1'b1;
    OE    = 1'b1;
    repeat (2) tick();

    // Reset with CP and STR high, then release with CP still high.
    RST_N = 1'b0;
    #1;
    push_exp(mko(8'h00, 1'b0, 1'b0, 1'b0));
    check_front("reset_state");
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (4) tick();
    push_exp(mko(8'h00, 1'b1, 1'b0, 1'b0));
    check_front("release_no_shift");
    CP = 1'b0;
    repeat (3) tick();

    run_table_shift();

    // One more rise with D=0: QS1 drops after the rise, QS2 only on the fall.
    D  = 1'b0;
    CP = 1'b1;
    push_exp(mko(8'hB2, 1'b1, 1'b1, 1'b1));
    repeat (LAT - 1) tick();
    check_front("qs1_before_rise");
    push_exp(mko(8'hB2, 1'b1, 1'b0, 1'b1));
    tick();
    check_front("qs1_after_rise");
    repeat (2) tick();
    CP = 1'b0;
    push_exp(mko(8'hB2, 1'b1, 1'b0, 1'b1));
    repeat (LAT - 1) tick();
    check_front("qs2_before_fall");
    push_exp(mko(8'hB2, 1'b1, 1'b0, 1'b0));
    tick();
    check_front("qs2_after_fall");
    repeat (2) tick();

    OE = 1'b0;
    push_exp(mko(8'hB2, 1'b1, 1'b0, 1'b0));
    repeat (LAT - 1) tick();
    check_front("oe_off_before");
    push_exp(mko(8'h00, 1'b0, 1'b0, 1'b0));
    tick();
    check_front("oe_off_after");
    repeat (2) tick();
    OE = 1'b1;
    push_exp(mko(8'h00, 1'b0, 1'b0, 1'b0));
    repeat (LAT - 1) tick();
    check_front("oe_on_before");
    push_exp(mko(8'hB2, 1'b1, 1'b0, 1'b0));
    tick();
    check_front("oe_on_after");
    repeat (2) tick();

    // Reset asserted in the middle of a rise cycle.
    D  = 1'b1;
    CP = 1'b1;
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    push_exp(mko(8'h00, 1'b0, 1'b0, 1'b0));
    check_front("midop_reset");
    repeat (2) tick();
    STR   = 1'b1;
    RST_N = 1'b1;
    repeat (4) tick();
    push_exp(mko(8'h00, 1'b1, 1'b0, 1'b0));
    check_front("midop_release");
    CP = 1'b0;
    repeat (3) tick();

    run_table_walk();

    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
